// File: rtl/trng_pkg.sv
// Shared types and defaults for the SR-latch TRNG sequencer.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_PUSH,
    ST_FAIL
  } state_t;

  localparam int DEF_RESET_CYCLES  = 2;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_REP_LIMIT     = 8;
  localparam int DEF_WIDTH         = 8;

  // Bits needed for a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test: trips when REP_LIMIT consecutive samples are equal.
module trng_rep_test #(
  parameter int REP_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic ent_bit,
  input  logic clear,
  output logic trip
);

  logic [7:0] rep_cnt;
  logic [7:0] rep_nxt;
  logic       last_bit;

  // rep_cnt == 0 marks "no previous sample" after reset or clear.
  always_comb begin
    rep_nxt = 8'd1;
    if (rep_cnt != 8'd0 && ent_bit == last_bit) rep_nxt = rep_cnt + 8'd1;
    trip = sample && (rep_nxt == 8'(REP_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt  <= 8'd0;
      last_bit <= 1'b0;
    end else if (clear) begin
      rep_cnt  <= 8'd0;
      last_bit <= 1'b0;
    end else if (sample) begin
      rep_cnt  <= rep_nxt;
      last_bit <= ent_bit;
    end
  end

endmodule

// File: rtl/trng_sequencer.sv
// Sequencer for the SR-latch entropy network: hold/release/sample timing,
// word packing onto a valid/ready port, and repetition-test lockout.
//
// state     | meaning
// ST_IDLE   | latches held, waiting for enable
// ST_HOLD   | latches held in reset for RESET_CYCLES
// ST_SETTLE | latches released, racing for SETTLE_CYCLES
// ST_SAMPLE | one cycle: capture raw bit, update health test
// ST_PUSH   | word presented until handshake
// ST_FAIL   | health test tripped; sticky until clear_fail
module trng_sequencer
  import trng_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int REP_LIMIT     = DEF_REP_LIMIT,
  parameter int WIDTH         = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ent_bit,
  output logic             latch_hold,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             health_fail,
  input  logic             clear_fail
);

  localparam int PHASE_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int PW = cnt_width(PHASE_MAX);
  localparam int BW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg, shift_in;
  logic             sample_go, trip, handshake, word_done;

  logic             latch_hold_d, rnd_valid_d, health_fail_d;
  logic [WIDTH-1:0] rnd_data_d;

  // A SAMPLE cycle with enable low is an abort: the bit is not taken.
  assign sample_go = (state == ST_SAMPLE) && enable;
  assign handshake = (state == ST_PUSH) && rnd_ready;
  assign word_done = (bit_cnt == BW'(WIDTH - 1));
  assign shift_in  = {shift_reg[WIDTH-2:0], ent_bit};

  trng_rep_test #(.REP_LIMIT(REP_LIMIT)) u_rep_test (
    .clk     (clk),
    .rst_n   (rst_n),
    .sample  (sample_go),
    .ent_bit (ent_bit),
    .clear   ((state == ST_FAIL) && clear_fail),
    .trip    (trip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (enable) state_nxt = ST_HOLD;
      ST_HOLD:   if (!enable) state_nxt = ST_IDLE;
                 else if (phase == '0) state_nxt = ST_SETTLE;
      ST_SETTLE: if (!enable) state_nxt = ST_IDLE;
                 else if (phase == '0) state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (!enable) state_nxt = ST_IDLE;
                 else if (trip) state_nxt = ST_FAIL;
                 else if (word_done) state_nxt = ST_PUSH;
                 else state_nxt = ST_HOLD;
      ST_PUSH:   if (rnd_ready) state_nxt = enable ? ST_HOLD : ST_IDLE;
      ST_FAIL:   if (clear_fail) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_hold_d  = !(state_nxt == ST_SETTLE || state_nxt == ST_SAMPLE);
    rnd_valid_d   = (state_nxt == ST_PUSH);
    health_fail_d = (state_nxt == ST_FAIL);
    rnd_data_d    = '0;
    if (state_nxt == ST_PUSH) rnd_data_d = (state == ST_SAMPLE) ? shift_in : shift_reg;
  end

  // Down-counter loaded on entry to HOLD/SETTLE; terminal count is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (state_nxt == ST_HOLD && state != ST_HOLD) begin
      phase <= PW'(RESET_CYCLES - 1);
    end else if (state_nxt == ST_SETTLE && state != ST_SETTLE) begin
      phase <= PW'(SETTLE_CYCLES - 1);
    end else if (phase != '0) begin
      phase <= phase - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (sample_go && !trip) begin
      shift_reg <= shift_in;
      bit_cnt   <= bit_cnt + BW'(1);
    end else if (handshake || state_nxt == ST_IDLE || state_nxt == ST_FAIL) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_hold  <= 1'b1;
      rnd_valid   <= 1'b0;
      rnd_data    <= '0;
      health_fail <= 1'b0;
    end else begin
      latch_hold  <= latch_hold_d;
      rnd_valid   <= rnd_valid_d;
      rnd_data    <= rnd_data_d;
      health_fail <= health_fail_d;
    end
  end

endmodule

// File: doc/trng_sequencer.md
# trng_sequencer

Sequencer for the SR-latch entropy network. It holds the latches in their reset state, releases them into the metastable race, and samples the XOR-reduced raw bit. It packs WIDTH bits into a word and presents the word on a valid/ready output port. It also runs a repetition-count health test that locks the generator out when a stuck source is detected.

## Interface
- RESET_CYCLES, default 2: cycles the latches are held in reset before each release (≥1).
- SETTLE_CYCLES, default 4: cycles after release before the raw bit is sampled (≥1).
- REP_LIMIT, default 8: count of consecutive identical samples that declares failure (2..255).
- WIDTH, default 8: bits per output word.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run generation; level-sensitive.
- ent_bit  in  1  raw XOR-reduced bit from the latch network.
- latch_hold  out  1  1 = latches forced to reset (s=0, r=1); 0 = release (s=r driven by network clock).
- rnd_data  out  WIDTH  random word; 0 whenever rnd_valid=0.
- rnd_valid  out  1  rnd_data valid.
- rnd_ready  in  1  consumer accepts word.
- health_fail  out  1  sticky repetition-test failure.
- clear_fail  in  1  clears a failure; ignored outside FAIL.

## Operation
- States: IDLE, HOLD, SETTLE, SAMPLE, PUSH, FAIL.
- IDLE: latch_hold=1. enable=1 → HOLD.
- HOLD: latch_hold=1 for RESET_CYCLES cycles → SETTLE.
- SETTLE: latch_hold=0 for SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE (1 cycle, latch_hold=0): shift_reg ← {shift_reg[WIDTH-2:0], ent_bit}, so the first bit lands in the MSB.
  - bit_cnt increments and the repetition test updates.
  - Next state: FAIL if the test trips; else PUSH if bit_cnt reaches WIDTH; else HOLD.
- PUSH: latch_hold=1, rnd_valid=1, rnd_data=shift_reg, held stable until rnd_valid & rnd_ready.
  - On handshake: bit_cnt and shift_reg clear.
  - Next state: HOLD if enable, else IDLE.
- Repetition test: rep_cnt counts consecutive equal samples; the first sample after reset or clear sets rep_cnt=1.
  - A sample equal to the previous one increments rep_cnt; a differing sample sets it to 1.
  - rep_cnt == REP_LIMIT → trip.
- FAIL: health_fail=1, latch_hold=1, rnd_valid=0, shift_reg and bit_cnt cleared.
  - clear_fail=1 → IDLE next cycle; health_fail and rep_cnt cleared.
- enable low in HOLD, SETTLE or SAMPLE → IDLE next cycle.
  - Partial word and bit_cnt are discarded; rep_cnt is kept.
  - A SAMPLE in that same cycle is still discarded.
- enable low in PUSH: the word is still delivered; then IDLE.
- Trip on the same SAMPLE that completes a word: FAIL wins; the word is never presented.

## Timing
- Reset values: latch_hold=1, rnd_valid=0, rnd_data=0, health_fail=0; state IDLE; all counters 0.
- Async reset mid-operation forces the reset values immediately, without waiting for a clock.
- Per bit: RESET_CYCLES + SETTLE_CYCLES + 1 cycles (7 with defaults).
- enable seen high in IDLE at edge 0, defaults:
  - HOLD occupies cycles 1–2, SETTLE cycles 3–6, SAMPLE cycle 7.
  - The 8th SAMPLE is cycle 56; rnd_valid=1 from cycle 57.
- Back-to-back words with rnd_ready=1: next HOLD starts the cycle after the handshake. Throughput is one word per WIDTH·7+1 cycles.
- health_fail rises the cycle after the tripping SAMPLE.
- All outputs are registered; no combinational path from ent_bit or rnd_ready to any output.

## Structure
- trng_pkg: state enum, default parameter constants, and a WIDTH-sized counter width function.
- Sub-module trng_rep_test holds rep_cnt, the last-bit register and the trip compare. Interface: sample strobe, bit, clear → trip.
- The top holds the FSM, phase counter, bit counter, shift register and output register. The latch network is instantiated beside it, not inside.

## Test plan
- Reset: rst_n=0 mid-SETTLE → latch_hold=1, rnd_valid=0, rnd_data=0, health_fail=0 within the same cycle.
- Word assembly: enable=1, ent_bit sequence 1,0,1,1,0,0,1,0 at the SAMPLE cycles, rnd_ready=1 → rnd_data=8'hB2, rnd_valid high at cycle 57 for exactly one cycle.
- Backpressure: rnd_ready=0 for 20 cycles after valid → rnd_data stable at 8'hB2 and latch_hold=1 throughout, no sampling; ready=1 → next HOLD the following cycle.
- Stuck source: ent_bit=1 constant, REP_LIMIT=8 → health_fail=1 after the 8th SAMPLE, rnd_valid never asserted; clear_fail pulse → IDLE, health_fail=0.
- Abort: enable dropped after 3 SAMPLEs → IDLE, latch_hold=1; re-enable with 8 fresh bits 0xFF→0x00 alternating pattern 8'h55 → rnd_data=8'h55, no stale bits.
- Trip-on-completion: REP_LIMIT=8, eight identical samples completing a word → FAIL, rnd_valid stays 0.
